gray_counter_gen: RTL and testbench

//  Parametrised successor to the 4-bit gray/binary counter. Provides a WIDTH-bit
//  up/down counter with enable, parallel load (binary or gray-coded) and a

---
 rtl/gray_counter_gen.sv | 105 ++++++++++
 tb/tb_gray_counter_gen.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_gen.sv
// rtl/gray_counter_gen.sv - parametrised up/down counter with registered binary and gray outputs
module gray_counter_gen #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_count,
  output logic [WIDTH-1:0] gray_count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;
  logic             w_next_sat;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_load_bin = load_gray ? gray2bin(load_val) : load_val;

  // Next-state selection: load beats count; limits either wrap or hold.
  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    w_next_sat  = 1'b0;
    if (load) begin
      w_next_bin = w_load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (r_bin == MAX) begin
          if (SATURATE) begin
            w_next_sat = 1'b1;
          end else begin
            w_next_bin  = ZERO;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_bin = r_bin + ONE;
        end
      end else begin
        if (r_bin == ZERO) begin
          if (SATURATE) begin
            w_next_sat = 1'b1;
          end else begin
            w_next_bin  = MAX;
            w_next_wrap = 1'b1;
          end
        end else begin
          w_next_bin = r_bin - ONE;
        end
      end
    end
  end

  // Gray is derived from the next binary value so both registers agree every cycle.
  assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bin  <= ZERO;
      r_gray <= ZERO;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_next_wrap;
      r_sat  <= w_next_sat;
    end
  end

  assign bin_count  = r_bin;
  assign gray_count = r_gray;
  assign wrap       = r_wrap;
  assign sat        = r_sat;
  assign tc         = up_dn ? (r_bin == MAX) : (r_bin == ZERO);

endmodule

// File: tb/tb_gray_counter_gen.sv
// tb/tb_gray_counter_gen.sv - self-checking bench for gray_counter_gen
module tb_gray_counter_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic       load_gray = 1'b0;
  logic [5:0] load_val = '0;

  logic [3:0] b4, g4, b4s, g4s;
  logic [5:0] b6, g6;
  logic       tc4, w4, s4, tc4s, w4s, s4s, tc6, w6, s6;

  int tests_run = 0;
  int tests_failed = 0;

  int W [3] = '{4, 4, 6};
  int S [3] = '{0, 1, 0};
  int m_bin [3];
  int m_wrap [3];
  int m_sat [3];
  int m_step [3];

  always #5 clk = ~clk;

  gray_counter_gen #(.WIDTH(4), .SATURATE(1'b0)) u_wrap4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .load_val(load_val[3:0]), .bin_count(b4), .gray_count(g4), .tc(tc4), .wrap(w4), .sat(s4)
  );

  gray_counter_gen #(.WIDTH(4), .SATURATE(1'b1)) u_sat4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .load_val(load_val[3:0]), .bin_count(b4s), .gray_count(g4s), .tc(tc4s), .wrap(w4s), .sat(s4s)
  );

  gray_counter_gen #(.WIDTH(6), .SATURATE(1'b0)) u_wrap6 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .load_val(load_val), .bin_count(b6), .gray_count(g6), .tc(tc6), .wrap(w6), .sat(s6)
  );

  function automatic int get_bin(input int i);
    case (i)
      0:       return int'(b4);
      1:       return int'(b4s);
      default: return int'(b6);
    endcase
  endfunction

  function automatic int get_gray(input int i);
    case (i)
      0:       return int'(g4);
      1:       return int'(g4s);
      default: return int'(g6);
    endcase
  endfunction

  function automatic int get_wrap(input int i);
    case (i)
      0:       return int'(w4);
      1:       return int'(w4s);
      default: return int'(w6);
    endcase
  endfunction

  function automatic int get_sat(input int i);
    case (i)
      0:       return int'(s4);
      1:       return int'(s4s);
      default: return int'(s6);
    endcase
  endfunction

  function automatic int get_tc(input int i);
    case (i)
      0:       return int'(tc4);
      1:       return int'(tc4s);
      default: return int'(tc6);
    endcase
  endfunction

  // One clock edge: predict from the inputs held across the edge, then sample 1 ns after.
  task automatic tick();
    int nb [3];
    int nw [3];
    int ns [3];
    int st [3];
    for (int i = 0; i < 3; i++) begin
      int maxv;
      int lv;
      maxv = (1 << W[i]) - 1;
      lv = int'(load_val) & maxv;
      nw[i] = 0;
      ns[i] = 0;
      st[i] = 0;
      nb[i] = m_bin[i];
      if (!rst) begin
        nb[i] = 0;
      end else if (load) begin
        if (load_gray) begin
          int b;
          int s;
          b = lv;
          s = lv >> 1;
          while (s != 0) begin
            b = b ^ s;
            s = s >> 1;
          end
          nb[i] = b;
        end else begin
          nb[i] = lv;
        end
      end else if (en) begin
        int t;
        t = m_bin[i] + (up_dn ? 1 : -1);
        if (t >= 0 && t <= maxv) begin
          nb[i] = t;
          st[i] = 1;
        end else if (S[i] != 0) begin
          ns[i] = 1;
        end else begin
          nb[i] = (t < 0) ? maxv : 0;
          nw[i] = 1;
          st[i] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_bin[i] = nb[i];
      m_wrap[i] = nw[i];
      m_sat[i] = ns[i];
      m_step[i] = st[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; up_dn = 1'b0; load = 1'b0;
    tick();
    tick();
    tests_run++;
    if (b4 !== 4'h0 || g4 !== 4'h0 || w4 !== 1'b0 || s4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: bin=%h gray=%h wrap=%b sat=%b, required 0 0 0 0", b4, g4, w4, s4);
    end
    tests_run++;
    if (tc4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_tc_down: tc=%b, required 1", tc4);
    end
  endtask

  task automatic test_count_up();
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] eb;
      logic ew;
      tick();
      eb = 4'(k % 16);
      ew = (k == 16);
      tests_run++;
      if (b4 !== eb || g4 !== gtab[k % 16] || w4 !== ew) begin
        tests_failed++;
        $display("FAIL count_up step %0d: bin=%h gray=%h wrap=%b, required %h %h %b",
                 k, b4, g4, w4, eb, gtab[k % 16], ew);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] eb [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
    rst = 1'b1; en = 1'b0; load = 1'b1; load_gray = 1'b0; load_val = 6'd2;
    tick();
    tests_run++;
    if (b4 !== 4'h2) begin
      tests_failed++;
      $display("FAIL down_load: bin=%h, required 2", b4);
    end
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (b4 !== eb[k] || w4 !== (k == 2) || tc4 !== (k == 1)) begin
        tests_failed++;
        $display("FAIL down_wrap step %0d: bin=%h wrap=%b tc=%b, required %h %b %b",
                 k, b4, w4, tc4, eb[k], (k == 2), (k == 1));
      end
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1; en = 1'b0; load = 1'b1; load_gray = 1'b0; load_val = 6'hE;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (b4s !== 4'hF || s4s !== (k != 0) || w4s !== 1'b0 || g4s !== 4'h8) begin
        tests_failed++;
        $display("FAIL sat_up step %0d: bin=%h gray=%h sat=%b wrap=%b, required F 8 %b 0",
                 k, b4s, g4s, s4s, w4s, (k != 0));
      end
    end
    en = 1'b0; load = 1'b1; load_val = 6'h1;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (b4s !== 4'h0 || s4s !== (k != 0) || w4s !== 1'b0 || tc4s !== 1'b1) begin
        tests_failed++;
        $display("FAIL sat_down step %0d: bin=%h sat=%b wrap=%b tc=%b, required 0 %b 0 1",
                 k, b4s, s4s, w4s, tc4s, (k != 0));
      end
    end
  endtask

  task automatic test_gray_load();
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_gray = 1'b1; load_val = 6'b001101;
    tick();
    tests_run++;
    if (b4 !== 4'h9 || g4 !== 4'hD) begin
      tests_failed++;
      $display("FAIL gray_load: bin=%h gray=%h, required 9 D", b4, g4);
    end
    load = 1'b0; load_gray = 1'b0;
    tick();
    tests_run++;
    if (b4 !== 4'hA || g4 !== 4'hF) begin
      tests_failed++;
      $display("FAIL gray_load_count: bin=%h gray=%h, required A F", b4, g4);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_gray = 1'b0; load_val = 6'h27;
    tick();
    tests_run++;
    if (b4 !== 0 || g4 !== 0 || w4 !== 0 || s4 !== 0 || b4s !== 0 || b6 !== 0 || g6 !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid: bin4=%h gray4=%h wrap=%b sat=%b bin4s=%h bin6=%h gray6=%h, required all 0",
               b4, g4, w4, s4, b4s, b6, g6);
    end
    rst = 1'b1; load = 1'b0;
    tick();
    tests_run++;
    if (b4 !== 4'h1 || b6 !== 6'h1) begin
      tests_failed++;
      $display("FAIL reset_first_count: bin4=%h bin6=%h, required 1 1", b4, b6);
    end
  endtask

  task automatic test_random();
    int prev_g [3];
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) prev_g[i] = get_gray(i);
      rst = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) < 7);
      up_dn = $urandom_range(0, 1);
      load = ($urandom_range(0, 9) == 0);
      load_gray = $urandom_range(0, 1);
      load_val = 6'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        int b;
        int g;
        int maxv;
        b = get_bin(i);
        g = get_gray(i);
        maxv = (1 << W[i]) - 1;
        tests_run++;
        if (b != m_bin[i] || get_wrap(i) != m_wrap[i] || get_sat(i) != m_sat[i]) begin
          tests_failed++;
          $display("FAIL random inst%0d cycle %0d: bin=%0d wrap=%0d sat=%0d, required %0d %0d %0d",
                   i, c, b, get_wrap(i), get_sat(i), m_bin[i], m_wrap[i], m_sat[i]);
        end
        tests_run++;
        if (g != (b ^ (b >> 1))) begin
          tests_failed++;
          $display("FAIL random_gray inst%0d cycle %0d: gray=%0d, required %0d", i, c, g, b ^ (b >> 1));
        end
        tests_run++;
        if (get_tc(i) != (up_dn ? (b == maxv) : (b == 0))) begin
          tests_failed++;
          $display("FAIL random_tc inst%0d cycle %0d: tc=%0d bin=%0d up_dn=%b", i, c, get_tc(i), b, up_dn);
        end
        if (m_step[i] != 0) begin
          tests_run++;
          if ($countones(32'(g ^ prev_g[i])) != 1) begin
            tests_failed++;
            $display("FAIL random_gray_step inst%0d cycle %0d: gray %0d -> %0d, required one-bit change",
                     i, c, prev_g[i], g);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_bin[i] = 0;
      m_wrap[i] = 0;
      m_sat[i] = 0;
      m_step[i] = 0;
    end
    test_reset();
    test_count_up();
    test_down_wrap();
    test_saturate();
    test_gray_load();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
